// File: rtl/reg_writeback_pkg.sv
// Shared widths (mirroring the codebase's define.v) and the writeback entry type.
package reg_writeback_pkg;

  localparam int unsigned RegAddrW = 5;   // RegAddrBus
  localparam int unsigned RegW     = 32;  // RegBus
  localparam int unsigned RegCnt   = 32;

  typedef struct packed {
    logic [RegAddrW-1:0] rd;
    logic [RegW-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular writeback FIFO with two push ports (a is older than b) and one pop port.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_a_i,
  input  wb_entry_t       entry_a_i,
  input  logic            push_b_i,
  input  wb_entry_t       entry_b_i,
  input  logic            pop_i,
  output wb_entry_t       head_o,
  output logic [CntW-1:0] count_o,
  output wb_entry_t       slots_o [Depth],
  output logic            slot_valid_o [Depth]
);

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pop;

  assign pop = pop_i && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CntW'(push_a_i) + CntW'(push_b_i) - CntW'(pop);
    if (pop) head_d = PtrW'(head_q + 1'b1);
    tail_d = PtrW'(tail_q + PtrW'(push_a_i) + PtrW'(push_b_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Port b lands behind port a when both push in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_a_i) mem_q[tail_q] <= entry_a_i;
      if (push_b_i) mem_q[push_a_i ? PtrW'(tail_q + 1'b1) : tail_q] <= entry_b_i;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      slots_o[i]      = mem_q[i];
      slot_valid_o[i] = CntW'(PtrW'(PtrW'(i) - head_q)) < count_q;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: merges load and ALU results into an ordered register-file write stream.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic [RegAddrW-1:0] mem_rd,
  input  logic [RegW-1:0]     mem_data,
  output logic                mem_ready,
  input  logic                ex_valid,
  input  logic [RegAddrW-1:0] ex_rd,
  input  logic [RegW-1:0]     ex_data,
  output logic                ex_ready,
  output logic                we,
  output logic [RegAddrW-1:0] w_addr,
  output logic [RegW-1:0]     w_data,
  output logic [RegCnt-1:0]   busy,
  output logic                empty
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wb_entry_t       head;
  wb_entry_t       slots [DEPTH];
  logic            slot_valid [DEPTH];
  logic [CntW-1:0] count;
  logic [CntW-1:0] free;
  logic            push_mem, push_ex;

  // Free space ignores this cycle's pop so readiness never depends on the pop path.
  assign free      = CntW'(DEPTH) - count;
  assign mem_ready = free >= CntW'(1);
  assign ex_ready  = (free >= CntW'(2)) || ((free == CntW'(1)) && !mem_valid);

  // x0 writes handshake normally but are dropped.
  assign push_mem = mem_valid && mem_ready && (mem_rd != '0);
  assign push_ex  = ex_valid && ex_ready && (ex_rd != '0);

  wb_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_a_i    (push_mem),
    .entry_a_i   ('{rd: mem_rd, data: mem_data}),
    .push_b_i    (push_ex),
    .entry_b_i   ('{rd: ex_rd, data: ex_data}),
    .pop_i       (1'b1),
    .head_o      (head),
    .count_o     (count),
    .slots_o     (slots),
    .slot_valid_o(slot_valid)
  );

  assign we     = count != '0;
  assign empty  = count == '0;
  assign w_addr = we ? head.rd : '0;
  assign w_data = we ? head.data : '0;

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) busy[slots[i].rd] = 1'b1;
    end
    busy[0] = 1'b0;
  end

endmodule
